// File: rtl/geofence_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : geofence_pkg                                               |
// | Description : Shared constants and FSM state type for the geofence       |
// |               feeder (host-side transmitter for the geofence engine).    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package geofence_pkg;

  localparam int GF_COORD_W = 10;   // engine X/Y coordinate width
  localparam int GF_NPTS    = 7;    // 1 test point + 6 fence vertices
  localparam int GF_TIMEOUT = 255;  // WAIT cycles before the job is aborted
  localparam int GF_IDX_W   = 3;    // point index width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } gf_state_e;

endpackage : geofence_pkg
`default_nettype wire

// File: rtl/geofence_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : geofence_feeder_if                                         |
// | Description : Host write/start/result bus plus the engine X/Y stream     |
// |               and result handshake. master = host/engine side,           |
// |               slave = feeder.                                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface geofence_feeder_if #(
  parameter int COORD_W = geofence_pkg::GF_COORD_W
);
  // host side
  logic               wr_en;
  logic [2:0]         wr_idx;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic               start;
  logic               busy;
  logic               res_valid;
  logic               res_inside;
  logic               res_timeout;
  // engine side
  logic               gf_reset;
  logic [COORD_W-1:0] gf_x;
  logic [COORD_W-1:0] gf_y;
  logic               gf_valid;
  logic               gf_is_inside;

  modport master (
    output wr_en, wr_idx, wr_x, wr_y, start, gf_valid, gf_is_inside,
    input  busy, res_valid, res_inside, res_timeout, gf_reset, gf_x, gf_y
  );

  modport slave (
    input  wr_en, wr_idx, wr_x, wr_y, start, gf_valid, gf_is_inside,
    output busy, res_valid, res_inside, res_timeout, gf_reset, gf_x, gf_y
  );
endinterface : geofence_feeder_if
`default_nettype wire

// File: rtl/geofence_pt_rf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : geofence_pt_rf                                             |
// | Description : NPTS x (2*COORD_W) point register file, one write port     |
// |               and one combinational read port. Not cleared by reset.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module geofence_pt_rf
  import geofence_pkg::*;
#(
  parameter int COORD_W = GF_COORD_W,
  parameter int NPTS    = GF_NPTS
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [GF_IDX_W-1:0] wr_idx_i,
  input  logic [COORD_W-1:0]  wr_x_i,
  input  logic [COORD_W-1:0]  wr_y_i,
  input  logic [GF_IDX_W-1:0] rd_idx_i,
  output logic [COORD_W-1:0]  rd_x_o,
  output logic [COORD_W-1:0]  rd_y_o
);

  localparam logic [GF_IDX_W-1:0] LAST_IDX = GF_IDX_W'(NPTS - 1);

  logic [2*COORD_W-1:0] mem_q [NPTS];

  // Write port: indices beyond the last point are dropped.
  always_ff @(posedge clk) begin
    if (wr_en_i && (wr_idx_i <= LAST_IDX)) begin
      mem_q[wr_idx_i] <= {wr_x_i, wr_y_i};
    end
  end

  // Read port: out-of-range index reads as zero.
  always_comb begin
    rd_x_o = '0;
    rd_y_o = '0;
    if (rd_idx_i <= LAST_IDX) begin
      {rd_x_o, rd_y_o} = mem_q[rd_idx_i];
    end
  end

endmodule : geofence_pt_rf
`default_nettype wire

// File: rtl/geofence_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : geofence_feeder                                            |
// | Description : Frames the geofence engine with a one-cycle reset, streams |
// |               the 7 job points, waits for the engine result (with        |
// |               timeout) and reports it to the host. Outputs registered.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module geofence_feeder
  import geofence_pkg::*;
#(
  parameter int COORD_W = GF_COORD_W,
  parameter int NPTS    = GF_NPTS,
  parameter int TIMEOUT = GF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  geofence_feeder_if.slave  bus
);

  // idx is one ahead of the point on the bus; reaching NPTS means the
  // last point is currently being driven.
  localparam logic [GF_IDX_W-1:0] END_IDX  = GF_IDX_W'(NPTS);
  localparam logic [7:0]          TMO_LAST = 8'(TIMEOUT - 1);

  gf_state_e             state_q, state_d;
  logic [GF_IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]            timer_q, timer_d;
  logic                  busy_q, busy_d;
  logic                  gf_reset_q, gf_reset_d;
  logic [COORD_W-1:0]    gf_x_q, gf_x_d;
  logic [COORD_W-1:0]    gf_y_q, gf_y_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_inside_q, res_inside_d;
  logic                  res_timeout_q, res_timeout_d;

  logic                  wr_en_w;
  logic [COORD_W-1:0]    rd_x_w, rd_y_w;

  // The host may only rewrite the job while nothing is in flight.
  assign wr_en_w = bus.wr_en && !busy_q;

  geofence_pt_rf #(
    .COORD_W (COORD_W),
    .NPTS    (NPTS)
  ) u_pt_rf (
    .clk      (clk),
    .wr_en_i  (wr_en_w),
    .wr_idx_i (bus.wr_idx),
    .wr_x_i   (bus.wr_x),
    .wr_y_i   (bus.wr_y),
    .rd_idx_i (idx_q),
    .rd_x_o   (rd_x_w),
    .rd_y_o   (rd_y_w)
  );

  // State and registered outputs; reset aborts any job and holds the engine in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      busy_q        <= 1'b0;
      gf_reset_q    <= 1'b1;
      gf_x_q        <= '0;
      gf_y_q        <= '0;
      res_valid_q   <= 1'b0;
      res_inside_q  <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      busy_q        <= busy_d;
      gf_reset_q    <= gf_reset_d;
      gf_x_q        <= gf_x_d;
      gf_y_q        <= gf_y_d;
      res_valid_q   <= res_valid_d;
      res_inside_q  <= res_inside_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  // Next state and next output values, computed one cycle ahead so every output is a flop.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = '0;
    gf_x_d        = '0;
    gf_y_d        = '0;
    res_valid_d   = 1'b0;
    res_inside_d  = 1'b0;
    res_timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (bus.start) begin
          state_d = ST_RST;
        end
      end
      ST_RST: begin
        // idx is 0 here, so point 0 follows the reset pulse directly.
        state_d = ST_SEND;
        gf_x_d  = rd_x_w;
        gf_y_d  = rd_y_w;
        idx_d   = idx_q + 1'b1;
      end
      ST_SEND: begin
        if (idx_q == END_IDX) begin
          state_d = ST_WAIT;
        end else begin
          gf_x_d = rd_x_w;
          gf_y_d = rd_y_w;
          idx_d  = idx_q + 1'b1;
        end
      end
      ST_WAIT: begin
        // A valid on the final timeout cycle still counts as a result.
        if (bus.gf_valid) begin
          state_d      = ST_DONE;
          res_valid_d  = 1'b1;
          res_inside_d = bus.gf_is_inside;
        end else if (timer_q == TMO_LAST) begin
          state_d       = ST_DONE;
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    gf_reset_d = (state_d == ST_RST);
  end

  assign bus.busy        = busy_q;
  assign bus.gf_reset    = gf_reset_q;
  assign bus.gf_x        = gf_x_q;
  assign bus.gf_y        = gf_y_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_inside  = res_inside_q;
  assign bus.res_timeout = res_timeout_q;

endmodule : geofence_feeder
`default_nettype wire
